// File: rtl/rs232_tx_streamer_if.sv
// Avalon-MM master bus plus the inbound byte stream for the RS232 transmit streamer.
// The master modport is the streamer side; the slave modport is the UART/arbiter and byte source side.
interface rs232_tx_streamer_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest,
        input  in_data,
        input  in_valid,
        output in_ready
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest,
        output in_data,
        output in_valid,
        input  in_ready
    );
endinterface

// File: rtl/rs232_tx_streamer.sv
// Buffers a byte stream in a FIFO and sends each byte to the UART TX register,
// polling the status register until TX_OK is set before every write.
module rs232_tx_streamer #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TX_BASE     = 4,
    parameter int unsigned STATUS_BASE = 8,
    parameter int unsigned TX_OK_BIT   = 6
) (
    input  logic                       avm_clk,
    input  logic                       avm_rst,
    rs232_tx_streamer_if.master        bus,
    output logic                       busy,
    output logic [15:0]                bytes_sent
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SENT_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_POLL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_BASE);
    localparam logic [ADDR_W-1:0] TX_ADDR     = ADDR_W'(TX_BASE);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              read_nx;
    logic              write_nx;
    logic [ADDR_W-1:0] address_nx;
    logic [DATA_W-1:0] writedata_nx;

    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [BYTE_W-1:0] head;
    logic              push;
    logic              pop;
    logic              slave_ready;
    logic              status_ok;
    logic              more_after_pop;

    assign bus.in_ready   = (count < CNT_W'(FIFO_DEPTH));
    assign push           = bus.in_valid & bus.in_ready;
    assign head           = mem[rd_ptr];
    assign slave_ready    = ~bus.avm_waitrequest;
    assign status_ok      = bus.avm_readdata[TX_OK_BIT];
    assign busy           = (state != S_IDLE) || (count != '0);
    // A push landing in the same cycle as the pop keeps the queue non-empty.
    assign more_after_pop = push || (count > CNT_W'(1));

    // Next-state and next-output logic; outputs hold unless a transition changes them.
    always_comb begin
        state_nx     = state;
        read_nx      = bus.avm_read;
        write_nx     = bus.avm_write;
        address_nx   = bus.avm_address;
        writedata_nx = bus.avm_writedata;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                read_nx  = 1'b0;
                write_nx = 1'b0;
                if (count != '0) begin
                    state_nx   = S_POLL;
                    read_nx    = 1'b1;
                    address_nx = STATUS_ADDR;
                end
            end
            S_POLL: begin
                // A not-ready status leaves avm_read high, which re-issues the read.
                if (slave_ready && status_ok) begin
                    state_nx     = S_WRITE;
                    read_nx      = 1'b0;
                    write_nx     = 1'b1;
                    address_nx   = TX_ADDR;
                    writedata_nx = {(DATA_W - BYTE_W)'(0), head};
                end
            end
            S_WRITE: begin
                if (slave_ready) begin
                    pop        = 1'b1;
                    write_nx   = 1'b0;
                    address_nx = STATUS_ADDR;
                    if (more_after_pop) begin
                        state_nx = S_POLL;
                        read_nx  = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                        read_nx  = 1'b0;
                    end
                end
            end
            default: begin
                state_nx   = S_IDLE;
                read_nx    = 1'b0;
                write_nx   = 1'b0;
                address_nx = STATUS_ADDR;
            end
        endcase
    end

    // State and Avalon output registers.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state             <= S_IDLE;
            bus.avm_read      <= 1'b0;
            bus.avm_write     <= 1'b0;
            bus.avm_address   <= STATUS_ADDR;
            bus.avm_writedata <= '0;
        end else begin
            state             <= state_nx;
            bus.avm_read      <= read_nx;
            bus.avm_write     <= write_nx;
            bus.avm_address   <= address_nx;
            bus.avm_writedata <= writedata_nx;
        end
    end

    // FIFO pointers, occupancy and sent-byte counter.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bytes_sent <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                bytes_sent <= bytes_sent + SENT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge avm_clk) begin
        if (push && !avm_rst) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_rs232_tx_streamer.sv
// Directed bench for rs232_tx_streamer: a bus monitor logs completed reads/writes and
// hand-computed expectations are compared at #1 after each rising edge.
module tb_rs232_tx_streamer;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] bytes_sent;

    rs232_tx_streamer_if bus ();

    rs232_tx_streamer dut (
        .avm_clk    (clk),
        .avm_rst    (rst),
        .bus        (bus.master),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rd     = 0;
    int          n_both   = 0;
    logic [31:0] wr_log[$];

    // Completed transfers as seen by the slave.
    always @(posedge clk) begin
        if (bus.avm_read && !bus.avm_waitrequest) n_rd++;
        if (bus.avm_write && !bus.avm_waitrequest) wr_log.push_back(bus.avm_writedata);
        if (bus.avm_read && bus.avm_write) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int rd0;
        int wr0;
        int acc;
        int base;
        bit done;
        bit pushing;

        rst                 = 1'b1;
        bus.in_valid        = 1'b1;
        bus.in_data         = 8'h55;
        bus.avm_readdata    = 32'h0;
        bus.avm_waitrequest = 1'b0;

        // Reset with in_valid held: nothing may be pushed.
        step();
        step();
        check("rst_read", 32'(bus.avm_read), 32'd0);
        check("rst_write", 32'(bus.avm_write), 32'd0);
        check("rst_addr", 32'(bus.avm_address), 32'd8);
        check("rst_wdata", bus.avm_writedata, 32'd0);
        check("rst_sent", 32'(bytes_sent), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single byte latency, TX_OK immediately.
        bus.avm_readdata = 32'h40;
        push_byte(8'hA5);
        check("lat_k_read", 32'(bus.avm_read), 32'd0);
        step();
        check("lat_k1_read", 32'(bus.avm_read), 32'd1);
        check("lat_k1_addr", 32'(bus.avm_address), 32'd8);
        check("lat_k1_write", 32'(bus.avm_write), 32'd0);
        step();
        check("lat_k2_write", 32'(bus.avm_write), 32'd1);
        check("lat_k2_read", 32'(bus.avm_read), 32'd0);
        check("lat_k2_addr", 32'(bus.avm_address), 32'd4);
        check("lat_k2_wdata", bus.avm_writedata, 32'h0000_00A5);
        step();
        check("lat_k3_sent", 32'(bytes_sent), 32'd1);
        check("lat_k3_busy", 32'(busy), 32'd0);
        check("lat_k3_write", 32'(bus.avm_write), 32'd0);

        // Five not-ready status reads, then ready.
        bus.avm_readdata = 32'h0;
        rd0 = n_rd;
        wr0 = wr_log.size();
        push_byte(8'h3C);
        step();
        repeat (5) step();
        check("poll_reads5", 32'(n_rd - rd0), 32'd5);
        check("poll_no_write", 32'(wr_log.size() - wr0), 32'd0);
        check("poll_write_low", 32'(bus.avm_write), 32'd0);
        check("poll_read_high", 32'(bus.avm_read), 32'd1);
        bus.avm_readdata = 32'h40;
        step();
        check("poll_reads6", 32'(n_rd - rd0), 32'd6);
        check("poll_w_strobe", 32'(bus.avm_write), 32'd1);
        check("poll_w_data", bus.avm_writedata, 32'h0000_003C);
        step();
        check("poll_writes", 32'(wr_log.size() - wr0), 32'd1);
        check("poll_log", wr_log[wr0], 32'h0000_003C);
        check("poll_sent", 32'(bytes_sent), 32'd2);

        // Write stall of three cycles with a byte pushed during the stall.
        push_byte(8'h11);
        step();
        step();
        check("stall0_write", 32'(bus.avm_write), 32'd1);
        check("stall0_wdata", bus.avm_writedata, 32'h0000_0011);
        bus.avm_waitrequest = 1'b1;
        bus.in_valid        = 1'b1;
        bus.in_data         = 8'h22;
        for (int i = 1; i <= 3; i++) begin
            step();
            bus.in_valid = 1'b0;
            check($sformatf("stall%0d_write", i), 32'(bus.avm_write), 32'd1);
            check($sformatf("stall%0d_addr", i), 32'(bus.avm_address), 32'd4);
            check($sformatf("stall%0d_wdata", i), bus.avm_writedata, 32'h0000_0011);
        end
        check("stall_sent_hold", 32'(bytes_sent), 32'd2);
        bus.avm_waitrequest = 1'b0;
        step();
        check("stall_pop_sent", 32'(bytes_sent), 32'd3);
        check("stall_repoll", 32'(bus.avm_read), 32'd1);
        check("stall_wlow", 32'(bus.avm_write), 32'd0);
        step();
        check("stall_next_wdata", bus.avm_writedata, 32'h0000_0022);
        step();
        check("stall_next_sent", 32'(bytes_sent), 32'd4);
        check("stall_idle", 32'(busy), 32'd0);

        // Fill past capacity with TX_OK low, then drain in order.
        bus.avm_readdata = 32'h0;
        base = wr_log.size();
        acc  = 0;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            if (bus.in_ready) acc++;
            step();
        end
        check("full_accepts", 32'(acc), 32'd16);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_no_write", 32'(wr_log.size() - base), 32'd0);
        bus.avm_readdata = 32'h40;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            pushing = bus.in_valid && bus.in_ready;
            step();
            if (pushing) bus.in_valid = 1'b0;
            if (bytes_sent == 16'd21) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        check("drain_sent", 32'(bytes_sent), 32'd21);
        check("drain_count", 32'(wr_log.size() - base), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (base + i < wr_log.size())
                check($sformatf("drain_order%0d", i), wr_log[base + i], 32'(i));
            else
                check($sformatf("drain_missing%0d", i), 32'hFFFF_FFFF, 32'(i));
        end
        step();
        step();
        check("drain_idle", 32'(busy), 32'd0);

        // Reset during a write stall with three bytes queued.
        push_byte(8'h70);
        push_byte(8'h71);
        push_byte(8'h72);
        bus.avm_waitrequest = 1'b1;
        step();
        check("abort_pre_write", 32'(bus.avm_write), 32'd1);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("abort_read", 32'(bus.avm_read), 32'd0);
        check("abort_write", 32'(bus.avm_write), 32'd0);
        check("abort_addr", 32'(bus.avm_address), 32'd8);
        check("abort_sent", 32'(bytes_sent), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        rst                 = 1'b0;
        bus.avm_waitrequest = 1'b0;
        rd0 = n_rd;
        wr0 = wr_log.size();
        repeat (10) step();
        check("abort_quiet_rd", 32'(n_rd - rd0), 32'd0);
        check("abort_quiet_wr", 32'(wr_log.size() - wr0), 32'd0);
        check("abort_quiet_busy", 32'(busy), 32'd0);
        check("abort_quiet_read", 32'(bus.avm_read), 32'd0);

        // After the abort, a fresh byte goes through normally.
        push_byte(8'h5A);
        step();
        step();
        check("fresh_wdata", bus.avm_writedata, 32'h0000_005A);
        step();
        check("fresh_sent", 32'(bytes_sent), 32'd1);

        check("rw_exclusive", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rs232_tx_streamer.md
Name: rs232_tx_streamer

Overview:
- Avalon-MM master that drives the RS232 UART IP core's transmit side, sending bytes from the FPGA back to the host PC.
- Bytes arrive on a valid/ready byte stream (e.g. processed pixel values) and are buffered in an internal FIFO.
- For each byte the block polls the UART status register until TX_OK is set, then writes the byte to the TX register.
- It shares the UART core's Avalon slave with the receive-side master through the system arbiter.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 2.
- TX_BASE, 4, byte address of the UART TX data register.
- STATUS_BASE, 8, byte address of the UART status register.
- TX_OK_BIT, 6, bit index of TX-ready in status readdata.

Ports:
- avm_clk  in  1  system clock; all logic on its rising edge.
- avm_rst  in  1  reset, synchronous, active-high.
- avm_address  out  5  Avalon address, registered.
- avm_read  out  1  Avalon read strobe, registered.
- avm_readdata  in  32  Avalon read data; valid in the cycle avm_read=1 and avm_waitrequest=0.
- avm_write  out  1  Avalon write strobe, registered.
- avm_writedata  out  32  {24'b0, byte}, registered.
- avm_waitrequest  in  1  slave stall.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH), combinational from registered count.
- busy  out  1  (state != S_IDLE) or (count != 0).
- bytes_sent  out  16  count of completed TX writes; wraps 65535 -> 0.

Behaviour:
- Reset (avm_rst=1 at an edge):
  - state=S_IDLE; avm_read=0; avm_write=0; avm_address=STATUS_BASE; avm_writedata=0.
  - FIFO pointers and count cleared; bytes_sent=0; in_ready=1 after the edge.
  - Reset mid-transaction aborts it: strobes deassert at that edge, and the FIFO contents are discarded.
- FIFO:
  - push = in_valid & in_ready; pop = completed TX write.
  - Push and pop in the same cycle leave count unchanged. This is legal when full: in_ready is low, so no push occurs.
  - Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- FSM states S_IDLE, S_POLL, S_WRITE; all outputs registered:
  - S_IDLE: strobes low. If count != 0, then next edge: state=S_POLL, avm_read=1, avm_address=STATUS_BASE.
  - S_POLL: hold avm_read and avm_address while avm_waitrequest=1.
    - On avm_waitrequest=0 with avm_readdata[TX_OK_BIT]=1, next edge: avm_read=0, avm_write=1, avm_address=TX_BASE, avm_writedata={24'b0, FIFO head}, state=S_WRITE.
    - On avm_waitrequest=0 with the bit 0: remain in S_POLL with avm_read held at 1, so a new read issues next cycle.
  - S_WRITE: hold avm_write, avm_address and avm_writedata stable while avm_waitrequest=1.
    - On avm_waitrequest=0: pop FIFO and increment bytes_sent (wrapping).
    - If count after the pop is nonzero: next edge avm_write=0, avm_read=1, avm_address=STATUS_BASE, state=S_POLL.
    - Otherwise: strobes low, avm_address=STATUS_BASE, state=S_IDLE.
- Invariants:
  - avm_read and avm_write are never both 1.
  - avm_writedata changes only on entry to S_WRITE.
  - Bytes pushed while in S_POLL or S_WRITE never alter the in-flight byte.
- Latency:
  - Byte pushed into an empty, idle block at edge k: avm_read=1 after edge k+1.
  - With zero waitrequest and TX_OK=1: avm_write=1 after edge k+2, bytes_sent increments at edge k+3.
  - Back-to-back bytes take 2 cycles each at best.
- Every TX write is preceded by a status read that returned TX_OK=1.

Test Plan:
- Reset with in_valid=1 held → after the reset edge: avm_read=0, avm_write=0, avm_address=8, bytes_sent=0, in_ready=1, busy=0. No push occurs while avm_rst=1.
- Push 0xA5 at edge k; slave has waitrequest=0 and returns status 0x40 → avm_read=1/addr 8 after edge k+1; avm_write=1/addr 4/writedata 0x000000A5 after edge k+2; bytes_sent=1 and busy=0 after edge k+3.
- Status returns 0x00 for 5 reads, then 0x40 → exactly 6 reads issue, then one write of the queued byte; no write appears during the 0x00 reads.
- Write phase with waitrequest=1 for 3 cycles → avm_write, avm_address=4 and avm_writedata stay stable for 4 cycles; pop happens once; a byte pushed during the stall is sent next.
- Push 17 bytes 0x00..0x10 back-to-back with TX_OK=0 → in_ready drops after 16 accepts. Then set TX_OK=1 → writes occur in order 0x00..0x10, in_ready returns high, bytes_sent=17.
- Assert avm_rst during S_WRITE stall with 3 bytes queued → strobes low after that edge, count=0, bytes_sent=0; no further Avalon traffic until a new push.
